// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op_val);
    return op_val[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op_val);
    return ~op_val[0];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The remainder stays below the divisor, so the difference always fits in WIDTH bits.
  always_comb begin
    shifted = {rem_in, shift_in};
    diff    = shifted[WIDTH-1:0] - divisor;
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO; one radix-2 step per cycle.
// Build option MDU_FAST_MULT_EN: multiplies finish in two cycles using a combinational product.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] move_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PROD_W = 2 * WIDTH;

  mdu_state_e       state, state_next;
  logic             div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             dbz_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;

  mdu_op_e          op_in_c;
  logic             in_div_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic             b_zero_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  logic [WIDTH:0]   mul_add_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] div_rem_c;
  logic             div_qbit_c;

  logic [PROD_W-1:0] prod_raw_c;
  logic [PROD_W-1:0] prod_c;
  logic [WIDTH-1:0]  quo_c;
  logic [WIDTH-1:0]  rem_c;

  // Operand decode and magnitude conversion at acceptance.
  always_comb begin
    op_in_c  = mdu_op_e'(op);
    in_div_c = op_is_div(op_in_c);
    a_neg_c  = op_is_signed(op_in_c) & operand_a[WIDTH-1];
    b_neg_c  = op_is_signed(op_in_c) & operand_b[WIDTH-1];
    b_zero_c = (operand_b == '0);
    a_mag_c  = a_neg_c ? -operand_a : operand_a;
    b_mag_c  = b_neg_c ? -operand_b : operand_b;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (in_div_c && b_zero_c) begin
            state_next = FINISH;
          end
`ifdef MDU_FAST_MULT_EN
          else if (!in_div_c) begin
            state_next = FINISH;
          end
`endif
          else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift-add multiply step: acc_hi accumulates, acc_lo shifts out multiplier bits.
  always_comb begin
    mul_add_c = acc_lo_q[0] ? {1'b0, opnd_q} : '0;
    mul_sum_c = {1'b0, acc_hi_q} + mul_add_c;
  end

  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in   (acc_hi_q),
    .shift_in (acc_lo_q[WIDTH-1]),
    .divisor  (opnd_q),
    .rem_out  (div_rem_c),
    .q_bit    (div_qbit_c)
  );

  // Sign correction applied when results are committed.
  always_comb begin
`ifdef MDU_FAST_MULT_EN
    prod_raw_c = PROD_W'(opnd_q) * PROD_W'(acc_lo_q);
`else
    prod_raw_c = {acc_hi_q, acc_lo_q};
`endif
    prod_c = neg_lo_q ? -prod_raw_c : prod_raw_c;
    quo_c  = neg_lo_q ? -acc_lo_q : acc_lo_q;
    rem_c  = neg_hi_q ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_q       <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      dbz_q       <= 1'b0;
      cnt_q       <= '0;
      opnd_q      <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != IDLE);
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            div_q <= in_div_c;
            cnt_q <= '0;
            if (in_div_c && b_zero_c) begin
              // Divide by zero: preload the fixed result and skip iteration.
              acc_hi_q <= operand_a;
              acc_lo_q <= '1;
              opnd_q   <= operand_b;
              neg_lo_q <= 1'b0;
              neg_hi_q <= 1'b0;
              dbz_q    <= 1'b1;
            end else if (in_div_c) begin
              acc_hi_q <= '0;
              acc_lo_q <= a_mag_c;
              opnd_q   <= b_mag_c;
              neg_lo_q <= a_neg_c ^ b_neg_c;
              neg_hi_q <= a_neg_c;
              dbz_q    <= 1'b0;
            end else begin
              acc_hi_q <= '0;
              acc_lo_q <= b_mag_c;
              opnd_q   <= a_mag_c;
              neg_lo_q <= a_neg_c ^ b_neg_c;
              neg_hi_q <= a_neg_c ^ b_neg_c;
              dbz_q    <= 1'b0;
            end
          end else begin
            if (hi_we) hi <= move_data;
            if (lo_we) lo <= move_data;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (div_q) begin
            acc_hi_q <= div_rem_c;
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_qbit_c};
          end else begin
            acc_hi_q <= mul_sum_c[WIDTH:1];
            acc_lo_q <= {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        FINISH: begin
          done        <= 1'b1;
          div_by_zero <= dbz_q;
          if (div_q) begin
            hi <= rem_c;
            lo <= quo_c;
          end else begin
            {hi, lo} <= prod_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of operations plus reset/move/restart sequences.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] move_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  always #5 clock = ~clock;

  mult_div_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .move_data   (move_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] b);
    if (o[1] && b == 32'h0) return 2;
`ifdef MDU_FAST_MULT_EN
    if (!o[1]) return 2;
`endif
    return 34;
  endfunction

  // Issue one operation; optionally re-pulse start or attempt a move while busy.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int repulse_at, input int mv_at);
    int cyc;
    int lat;
    bit seen;
    lat  = lat_of(o, b);
    seen = 1'b0;
    cyc  = 0;
    @(negedge clock);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clock);
    while (!seen && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
      end
      if (repulse_at > 0 && cyc == repulse_at && cyc < lat) start = 1'b1;
      if (repulse_at > 0 && cyc == repulse_at + 1) start = 1'b0;
      if (mv_at > 0 && mv_at + 1 < lat) begin
        if (cyc == mv_at) begin
          lo_we = 1'b1; hi_we = 1'b1; move_data = 32'hDEAD_BEEF;
        end
        if (cyc == mv_at + 1) begin
          lo_we = 1'b0; hi_we = 1'b0;
          chk({nm, " lo_held_busy"}, {32'h0, lo}, {32'h0, model_lo});
          chk({nm, " hi_held_busy"}, {32'h0, hi}, {32'h0, model_hi});
        end
      end
      chk($sformatf("%s busy@%0d", nm, cyc), {63'h0, busy}, {63'h0, cyc < lat});
      if (done) seen = 1'b1;
    end
    chk({nm, " done_cycle"}, 64'(cyc), 64'(lat));
    chk({nm, " hi"}, {32'h0, hi}, {32'h0, ehi});
    chk({nm, " lo"}, {32'h0, lo}, {32'h0, elo});
    chk({nm, " dbz"}, {63'h0, div_by_zero}, {63'h0, edbz});
    model_hi = ehi;
    model_lo = elo;
    @(negedge clock);
    chk({nm, " done_pulse"}, {62'h0, done, div_by_zero}, 64'h0);
    if (repulse_at > 0) begin
      bit extra;
      extra = 1'b0;
      repeat (40) begin
        @(negedge clock);
        if (done || busy) extra = 1'b1;
      end
      chk({nm, " no_second_done"}, {63'h0, extra}, 64'h0);
      chk({nm, " hi_kept"}, {32'h0, hi}, {32'h0, ehi});
    end
  endtask

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[2]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[6]  = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b00, 32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'b00, 32'd6,         32'd7,         32'h0000_0000, 32'd42,        1'b0};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};

    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; move_data = '0;
    repeat (3) @(negedge clock);
    chk("reset_state", {busy, done, div_by_zero, 29'h0, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    reset = 1'b0;

    // mthi / mtlo in IDLE
    @(negedge clock);
    hi_we = 1'b1; move_data = 32'h0000_1234;
    @(negedge clock);
    hi_we = 1'b0;
    chk("mthi", {32'h0, hi}, 64'h1234);
    lo_we = 1'b1; move_data = 32'h0000_5678;
    @(negedge clock);
    lo_we = 1'b0;
    chk("mtlo", {32'h0, lo}, 64'h5678);
    chk("mtlo_hi_kept", {32'h0, hi}, 64'h1234);
    model_hi = 32'h1234;
    model_lo = 32'h5678;

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz, 0, 0);
    end

    // Restart attempt while busy must be ignored.
    run_op("mult_repulse", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 10, 0);

    // mthi/mtlo while busy must be dropped.
    run_op("move_busy", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 0, 5);

    // Reset in the middle of a divide.
    @(negedge clock);
    op = 2'b11; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    chk("pre_reset_busy", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_reset_state", {busy, done, div_by_zero, 29'h0, hi}, 64'h0);
    chk("mid_reset_lo", {32'h0, lo}, 64'h0);
    model_hi = '0;
    model_lo = '0;
    begin
      bit stray;
      stray = 1'b0;
      repeat (40) begin
        @(negedge clock);
        if (done || busy) stray = 1'b1;
      end
      chk("mid_reset_no_done", {63'h0, stray}, 64'h0);
    end
    run_op("after_reset", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Takes the same register operands as the ALU (rs/rt read data) and owns the architectural HI/LO registers.
- Executes mult/multu/div/divu over multiple cycles and provides HI/LO to the mfhi/mflo writeback path.
- Exposes `busy` so the controller stalls dependent instructions.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request to begin an operation; sampled only in IDLE
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu
- operand_a  in  WIDTH  rs value (multiplicand / dividend)
- operand_b  in  WIDTH  rt value (multiplier / divisor)
- hi_we  in  1  mthi write enable
- lo_we  in  1  mtlo write enable
- move_data  in  WIDTH  data for mthi/mtlo
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when HI/LO hold a new result
- div_by_zero  out  1  high together with done when a div/divu had divisor 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE. busy=0, done=0, div_by_zero=0, hi=0, lo=0. Reset overrides everything, including mid-operation; the partial result is discarded and HI/LO clear.
- State machine has three states: IDLE, CALC, FINISH.
- IDLE, start=1:
  - Latches op and the operands.
  - For signed ops, converts operands to magnitudes and records the result signs.
  - Clears the iteration counter, goes to CALC, busy=1 from the next cycle.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter increments each step. After WIDTH steps, goes to FINISH.
- FINISH:
  - Applies sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes HI/LO, pulses done=1, drops busy, returns to IDLE.
- Latency: start accepted at cycle 0; done and the new HI/LO are visible at cycle WIDTH+2 (34 for WIDTH=32). Each result is also observable via hi/lo thereafter.
- Result mapping:
  - mult/multu: {HI,LO} = full 2*WIDTH product.
  - div/divu: LO = quotient, HI = remainder.
- Divisor zero:
  - No CALC iterations; goes IDLE -> FINISH directly (done at cycle 2).
  - HI = operand_a, LO = all ones, div_by_zero=1 for the done cycle.
- Signed overflow (div, most-negative / -1): LO = most-negative value, HI = 0. Normal 34-cycle latency.
- start while busy is ignored; the in-flight operation is not affected.
- mthi/mtlo:
  - hi_we/lo_we take effect on the next edge only when in IDLE and not starting.
  - Ignored while busy.
  - If start and a move are asserted together in IDLE, start wins and the move is dropped. The controller never issues both.
- done and div_by_zero are single-cycle pulses; both are 0 in every other cycle.
- Operands are sampled only at acceptance; input changes during CALC have no effect.

Optional Feature:
- Macro MDU_FAST_MULT_EN.
- Defined: mult/multu bypass CALC. The full product is computed combinationally from the latched magnitudes, and the unit goes IDLE -> FINISH, so done comes at cycle 2. Divide is unchanged.
- Undefined: all ops are iterative as above.

Decomposition:
- Package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state typedef {IDLE, CALC, FINISH};
  - default WIDTH constant.
- One sub-module, mdu_div_step: combinational restoring-divide step (remainder, quotient bit) instantiated once and used by the CALC datapath.
- Multiply step, sequencing, sign handling and HI/LO live in the top.

Test Plan:
- multu 0xFFFFFFFF * 0xFFFFFFFF -> done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001; busy high cycles 1-33.
- mult -7 * 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; start re-pulsed at cycle 10 is ignored, with no second done.
- div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100 / 7 -> LO=14, HI=2.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. divu 5 / 0 -> done at cycle 2, div_by_zero=1, HI=5, LO=0xFFFFFFFF.
- reset asserted at cycle 15 of a divide -> next cycle busy=0, hi=lo=0, no done; a new start then completes normally.
- mthi 0x1234 in IDLE -> hi=0x1234 next cycle. mtlo while busy -> lo unchanged. With MDU_FAST_MULT_EN: mult 6 * 7 -> done at cycle 2, LO=42.
